// File: rtl/oled_pkg.sv
// Shared display geometry and streamer state encoding, used by the page
// streamer and the monochrome framebuffer.
package oled_pkg;

  localparam int H_PIXELS_DEF = 128;
  localparam int V_PIXELS_DEF = 64;
  localparam int PAGES_DEF    = V_PIXELS_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/oled_page_streamer.sv
// Reads the framebuffer column by column and streams one SSD1306 page-format
// byte per column read, page-major, over a valid/ready handshake.
module oled_page_streamer
  import oled_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       fb_ready,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_r_mode,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last
);

  localparam int PAGES  = V_PIXELS / 8;
  localparam int COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIXELS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [PAGE_W-1:0]  page;
  logic [7:0]         dout_rev;
  logic [7:0]         page_ypos;
  logic               at_last;

  // Framebuffer delivers the topmost row in bit7; the display wants it in bit0.
  always_comb begin
    dout_rev = '0;
    for (int i = 0; i < 8; i++) begin
      dout_rev[i] = fb_dout[7-i];
    end
  end

  assign page_ypos = 8'(page) << 3;
  assign at_last   = (col == COL_LAST) && (page == PAGE_LAST);
  assign fb_r_mode = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      col     <= '0;
      page    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fb_re   <= 1'b0;
      fb_xpos <= '0;
      fb_ypos <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && fb_ready) begin
            col     <= '0;
            page    <= '0;
            busy    <= 1'b1;
            fb_re   <= 1'b1;
            fb_xpos <= '0;
            fb_ypos <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (fb_r_data_valid) begin
            m_data  <= dout_rev;
            m_last  <= at_last;
            m_valid <= 1'b1;
            fb_re   <= 1'b0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (at_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              if (col == COL_LAST) begin
                col  <= '0;
                page <= page + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              state <= ST_GAP;
            end
          end
        end
        // One idle cycle so the framebuffer read pipeline drains between reads.
        ST_GAP: begin
          fb_re   <= 1'b1;
          fb_xpos <= 8'(col);
          fb_ypos <= page_ypos;
          state   <= ST_REQ;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_page_streamer.sv
// Bench for oled_page_streamer with a behavioural monochrome framebuffer
// (one-cycle column read) and a page-format reference model.
module tb_oled_page_streamer;
  import oled_pkg::*;

  localparam int H     = H_PIXELS_DEF;
  localparam int V     = V_PIXELS_DEF;
  localparam int PAGES = V / 8;
  localparam int NB    = H * PAGES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       fb_ready = 1'b0;
  logic       fb_r_data_valid = 1'b0;
  logic [7:0] fb_dout = 8'h00;
  logic       m_ready = 1'b0;
  logic       busy, done, fb_re, fb_r_mode, m_valid, m_last;
  logic [7:0] fb_xpos, fb_ypos, m_data;

  oled_page_streamer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fb_ready(fb_ready), .fb_re(fb_re), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos),
    .fb_r_mode(fb_r_mode), .fb_r_data_valid(fb_r_data_valid), .fb_dout(fb_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Framebuffer model: pix[x][y]; column read answers one cycle after fb_re,
  // once per request, bit7 = row fb_ypos.
  bit pix [0:H-1][0:V-1];
  always @(posedge clk) begin
    fb_r_data_valid <= fb_re && !fb_r_data_valid;
    for (int k = 0; k < 8; k++) begin
      if (int'(fb_xpos) < H && int'(fb_ypos) + k < V)
        fb_dout[7-k] <= pix[fb_xpos][int'(fb_ypos) + k];
      else
        fb_dout[7-k] <= 1'b0;
    end
  end

  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    m_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got[$];
  bit         got_last[$];
  int         got_cyc[$];
  int         done_cnt = 0;
  int         viol = 0;
  bit         p_stall = 0, p_acc = 0;
  logic [7:0] p_data = 0;
  logic       p_last = 0;

  always @(negedge clk) begin
    if (fb_r_mode !== 1'b1) viol++;
    if (rst) begin
      p_stall = 0;
      p_acc   = 0;
    end else begin
      if (p_stall && !(m_valid === 1'b1 && m_data === p_data && m_last === p_last)) viol++;
      // accepted read: byte visible next cycle and fb_re dropped
      if (p_acc && (fb_re !== 1'b0 || m_valid !== 1'b1)) viol++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_last.push_back(m_last);
        got_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
      p_stall = m_valid && !m_ready;
      p_data  = m_data;
      p_last  = m_last;
      p_acc   = fb_re && fb_r_data_valid;
    end
  end

  // Page-format byte i: page i/H, column i%H, bit k = pixel row page*8+k.
  function automatic logic [7:0] exp_byte(input int i);
    logic [7:0] b;
    int pg = i / H;
    int c  = i % H;
    for (int k = 0; k < 8; k++) b[k] = pix[c][pg*8 + k];
    return b;
  endfunction

  function automatic int frame_diffs(input int base, output int first);
    int cnt = 0;
    first = -1;
    for (int i = 0; i < NB; i++) begin
      if (base + i >= got.size()) begin
        cnt++;
        if (first < 0) first = i;
      end else if (got[base+i] !== exp_byte(i) || got_last[base+i] !== (i == NB-1)) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (got.size() > base + NB) cnt += got.size() - (base + NB);
    return cnt;
  endfunction

  task automatic clear_fb();
    for (int x = 0; x < H; x++)
      for (int y = 0; y < V; y++) pix[x][y] = 1'b0;
  endtask

  task automatic random_fb();
    for (int x = 0; x < H; x++)
      for (int y = 0; y < V; y++) pix[x][y] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input int pct, input bit poke, output int base,
                           output int dones, output bit fin);
    int d0;
    ready_pct = pct;
    base = got.size();
    d0 = done_cnt;
    fin = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      @(posedge clk); #1;
      if (poke) start = (n == 200);
      if (done_cnt > d0) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    dones = done_cnt - d0;
    ready_pct = 100;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, fb_re, m_valid, m_last, fb_r_mode} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000001", {busy, done, fb_re, m_valid, m_last, fb_r_mode});
    end
    total++;
    if ({m_data, fb_xpos, fb_ypos} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 000000", {m_data, fb_xpos, fb_ypos});
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({busy, fb_re, m_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, fb_re, m_valid});
    end
  endtask

  task automatic test_clear_frame();
    int base, dones, first, v0, d;
    bit fin;
    clear_fb();
    fb_ready = 1'b1;
    v0 = viol;
    run_frame(100, 0, base, dones, fin);
    total++;
    if (!fin) begin bad++; $display("FAIL clear_timeout: no done within budget"); end
    d = frame_diffs(base, first);
    total++;
    if (d !== 0) begin
      bad++;
      $display("FAIL clear_bytes: %0d wrong (first %0d), want 0 wrong of %0d", d, first, NB);
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL clear_done: got %0d pulses want 1", dones); end
    total++;
    if (got.size() - base !== NB) begin
      bad++;
      $display("FAIL clear_count: got %0d bytes want %0d", got.size() - base, NB);
    end else begin
      total++;
      if (got_cyc[base+1] - got_cyc[base] !== 4) begin
        bad++;
        $display("FAIL byte_period: got %0d cycles want 4", got_cyc[base+1] - got_cyc[base]);
      end
      total++;
      if (got_cyc[base+NB-1] - got_cyc[base] !== 4 * (NB - 1)) begin
        bad++;
        $display("FAIL frame_span: got %0d cycles want %0d", got_cyc[base+NB-1] - got_cyc[base], 4 * (NB - 1));
      end
    end
    total++;
    if (viol - v0 !== 0) begin bad++; $display("FAIL clear_protocol: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_corner_pixels();
    int base, dones, first, d;
    bit fin;
    clear_fb();
    pix[0][0] = 1'b1;
    pix[H-1][V-1] = 1'b1;
    run_frame(100, 0, base, dones, fin);
    total++;
    if (got.size() - base < NB) begin
      bad++;
      $display("FAIL corner_count: got %0d bytes want %0d", got.size() - base, NB);
    end else begin
      total++;
      if (got[base] !== 8'h01) begin bad++; $display("FAIL corner_first: got %h want 01", got[base]); end
      total++;
      if (got[base+NB-1] !== 8'h80) begin bad++; $display("FAIL corner_last: got %h want 80", got[base+NB-1]); end
    end
    d = frame_diffs(base, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL corner_bytes: %0d wrong (first %0d) want 0", d, first); end
  endtask

  task automatic test_column();
    int base, dones, first, d, nz;
    bit fin;
    clear_fb();
    for (int y = 8; y < 16; y++) pix[5][y] = 1'b1;
    run_frame(100, 0, base, dones, fin);
    nz = 0;
    for (int i = base; i < got.size(); i++) if (got[i] !== 8'h00) nz++;
    total++;
    if (got.size() - base < NB) begin
      bad++;
      $display("FAIL column_count: got %0d bytes want %0d", got.size() - base, NB);
    end else begin
      total++;
      if (got[base+133] !== 8'hFF) begin bad++; $display("FAIL column_byte133: got %h want ff", got[base+133]); end
    end
    total++;
    if (nz !== 1) begin bad++; $display("FAIL column_nonzero: got %0d nonzero bytes want 1", nz); end
    d = frame_diffs(base, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL column_bytes: %0d wrong (first %0d) want 0", d, first); end
  endtask

  task automatic test_random_stall();
    int b1, b2, dones, first, d, v0, neq;
    bit fin;
    random_fb();
    v0 = viol;
    run_frame(100, 0, b1, dones, fin);
    d = frame_diffs(b1, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL rand_full: %0d wrong (first %0d) want 0", d, first); end
    run_frame(30, 0, b2, dones, fin);
    d = frame_diffs(b2, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL rand_stall: %0d wrong (first %0d) want 0", d, first); end
    neq = 0;
    for (int i = 0; i < NB; i++)
      if (b2 + i >= got.size() || b1 + i >= got.size() || got[b1+i] !== got[b2+i]) neq++;
    total++;
    if (neq !== 0) begin bad++; $display("FAIL stall_vs_full: %0d bytes differ want 0", neq); end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL stall_done: got %0d pulses want 1", dones); end
    total++;
    if (viol - v0 !== 0) begin bad++; $display("FAIL stall_protocol: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_ignored_start();
    int s0, base, dones, first, d;
    bit fin;
    random_fb();
    fb_ready = 1'b0;
    s0 = got.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if ({busy, fb_re, m_valid} !== 3'b000 || got.size() !== s0) begin
      bad++;
      $display("FAIL start_not_ready: busy/re/valid %b bytes %0d want 000 and 0", {busy, fb_re, m_valid}, got.size() - s0);
    end
    fb_ready = 1'b1;
    run_frame(100, 1, base, dones, fin);
    d = frame_diffs(base, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL start_while_busy: %0d wrong (first %0d) want 0", d, first); end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL busy_start_done: got %0d pulses want 1", dones); end
  endtask

  task automatic test_reset_midframe();
    int base, d0, dones, first, d, v0;
    bit fin, hit;
    random_fb();
    ready_pct = 100;
    base = got.size();
    d0 = done_cnt;
    v0 = viol;
    hit = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge clk); #1;
      if (got.size() - base >= 300 && m_valid === 1'b1) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL midframe_reach: byte 300 not reached within budget"); end
    rst = 1'b1;
    #1;
    total++;
    if ({fb_re, m_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL midframe_abort: re/valid/busy %b want 000", {fb_re, m_valid, busy});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (got.size() - base !== 300 || done_cnt !== d0) begin
      bad++;
      $display("FAIL midframe_quiet: bytes %0d dones %0d want 300 and 0", got.size() - base, done_cnt - d0);
    end
    total++;
    if (viol - v0 !== 0) begin bad++; $display("FAIL midframe_protocol: got %0d violations want 0", viol - v0); end
    run_frame(100, 0, base, dones, fin);
    d = frame_diffs(base, first);
    total++;
    if (d !== 0) begin bad++; $display("FAIL restart_frame: %0d wrong (first %0d) want 0", d, first); end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL restart_done: got %0d pulses want 1", dones); end
  endtask

  initial begin
    test_reset();
    test_clear_frame();
    test_corner_pixels();
    test_column();
    test_random_stall();
    test_ignored_start();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oled_page_streamer.md
OLED_PAGE_STREAMER -- requirements
Module: oled_page_streamer

Interface
REQ-001 Parameter H_PIXELS, default 128, display width in pixels (multiple of 8, max 256).
REQ-002 Parameter V_PIXELS, default 64, display height in pixels (multiple of 8); PAGES = V_PIXELS/8.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; it has no other clock or reset.
REQ-004 clk  in  1  the single module clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that requests streaming of one full frame.
REQ-007 busy  out  1  high from frame acceptance until done.
REQ-008 done  out  1  one-cycle pulse after the last byte handshake.
REQ-009 fb_ready  in  1  framebuffer clear complete (rst_complete); start is ignored while low.
REQ-010 fb_re  out  1  framebuffer read enable.
REQ-011 fb_xpos, fb_ypos  out  8 each  framebuffer read pixel coordinates.
REQ-012 fb_r_mode  out  1  framebuffer read mode; constant 1 (column read).
REQ-013 fb_r_data_valid  in  1  framebuffer read data valid.
REQ-014 fb_dout  in  8  framebuffer column data; bit7 = row fb_ypos, bit0 = row fb_ypos+7.
REQ-015 m_data  out  8  display byte; bit0 = top row of page (SSD1306 page format).
REQ-016 m_valid / m_ready  out / in  1 each  stream handshake to display transmitter.
REQ-017 m_last  out  1  high with the final byte of the frame (page PAGES-1, column H_PIXELS-1).

Function
REQ-018 States SHALL be IDLE, REQ, SEND, GAP, DONE.
REQ-019 IDLE: start && fb_ready -> REQ with col=0, page=0, busy=1; start in any other state or with fb_ready=0 is ignored.
REQ-020 REQ: fb_re=1, fb_xpos=col, fb_ypos=page*8; hold until fb_r_data_valid=1, then latch bit-reversed fb_dout into m_data, drive fb_re=0 and go to SEND.
REQ-021 SEND: m_valid=1; m_data and m_last SHALL stay stable until m_ready=1.
REQ-022 SEND, on m_valid && m_ready: if this is the last byte, go to DONE; otherwise advance the counters and go to GAP.
REQ-023 Counter advance: col increments; at col=H_PIXELS-1, col wraps to 0 and page increments.
REQ-024 GAP: fb_re=0 for exactly one cycle (clears the framebuffer read pipeline), then REQ.
REQ-025 fb_re SHALL be low for at least one cycle between consecutive reads.
REQ-026 DONE: done=1 and busy=0 for one cycle, then IDLE.
REQ-027 Bytes SHALL be emitted page-major, column-minor; exactly H_PIXELS*PAGES handshakes per frame.
REQ-028 Latency from fb_r_data_valid to m_valid SHALL be exactly 1 cycle.
REQ-029 Throughput with m_ready held high SHALL be one byte per (framebuffer column-read latency + 3) cycles.
REQ-030 m_ready stalling SHALL NOT lose, duplicate or reorder bytes.
REQ-031 fb_ypos = page*8 SHALL be computed without truncation; col and page counters SHALL be sized by clog2 of H_PIXELS and PAGES.

Reset
REQ-032 While rst=1: state=IDLE; busy, done, fb_re, m_valid, m_last = 0; m_data, fb_xpos, fb_ypos, col, page = 0; fb_r_mode = 1.
REQ-033 Reset mid-frame SHALL abort immediately, with no further fb_re or m_valid and no done pulse; the next start restarts at page 0, column 0.

Structure
REQ-034 H_PIXELS/V_PIXELS defaults, PAGES and the state encoding SHALL live in shared package oled_pkg, which the framebuffer also uses.
REQ-035 The block is a single FSM with counters and no sub-module; the bit reversal is inline combinational logic.

Verification
REQ-036 Bench instantiates framebuffer_monochrome as the read target: cleared buffer, start, m_ready=1 -> 1024 bytes all 0x00, m_last only on byte 1023, one done pulse.
REQ-037 Pixel (0,0) set (write 0x80 at x=0,y=0) -> byte 0 = 0x01; pixel (127,63) set -> byte 1023 = 0x80.
REQ-038 Column 5 rows 8..15 set -> byte 133 (page 1, column 5) = 0xFF and all other bytes 0x00.
REQ-039 m_ready random 30% duty -> byte sequence identical to the m_ready=1 run; m_data stable whenever m_valid && !m_ready.
REQ-040 start while busy, and start with fb_ready=0 -> ignored, no extra bytes; rst asserted at byte 300 -> fb_re and m_valid low in the same cycle, no done; a new start then yields a full 1024-byte frame.
REQ-041 Protocol check: fb_re never high in two adjacent reads without an intervening low cycle; fb_r_mode always 1.
